// File: rtl/mc_fifo_arbiter.sv
// mc_fifo_arbiter
//   NUM_CH independent circular FIFOs feeding one output port through a
//   round-robin arbiter. Once a word is shown and stalled, the arbiter locks
//   onto that channel, so data_o/ch_o cannot change until the handshake.
//
// Ports
//   clk, rst_n    : single clock, asynchronous active-low reset
//   data_i        : NUM_CH packed payloads, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   valid_i       : per-channel write request
//   grant_o       : per-channel write acceptance (= !full, 0 in reset)
//   grant_i       : downstream accepts the current output word
//   data_o, ch_o  : head word and index of the selected channel
//   valid_o       : data_o/ch_o hold a valid word
//   almost_full_o : per-channel count >= AF_LEVEL
//                   (present only with MC_FIFO_ALMOST_FULL_EN defined)

// One channel FIFO. Pointers carry an extra wrap bit to tell full from empty.
module mc_fifo_ch #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
`ifdef MC_FIFO_ALMOST_FULL_EN
    ,
    output logic [AW:0]           count
`endif
);
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + (AW+1)'(1);
        if (rd_en) rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rptr_q[AW-1:0]];
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
`ifdef MC_FIFO_ALMOST_FULL_EN
    assign count   = wptr_q - rptr_q;
`endif
endmodule

module mc_fifo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]            valid_i,
    output logic [NUM_CH-1:0]            grant_o,
    input  logic                         grant_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [CW-1:0]                ch_o,
    output logic                         valid_o
`ifdef MC_FIFO_ALMOST_FULL_EN
    ,
    output logic [NUM_CH-1:0]            almost_full_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_CH < 2 || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $error("mc_fifo_arbiter: unsupported DEPTH/NUM_CH/AF_LEVEL");
    end

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                           state_q, state_d;
    logic [CW-1:0]                    rr_q, rr_d, lock_q, lock_d;
    logic                             rdy_q;   // low in reset, high from first edge after release
    logic [CW-1:0]                    scan_ch, sel_ch;
    logic                             any_ne, hs;
    logic [NUM_CH-1:0]                full, empty, pop, push;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] head;
`ifdef MC_FIFO_ALMOST_FULL_EN
    logic [NUM_CH-1:0][AW:0]          count;
`endif

    // Full is sampled before the edge, so a read of a full channel does not
    // open it for a write in the same cycle.
    assign grant_o = rdy_q ? ~full : '0;
    assign push    = valid_i & grant_o;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pop[c] = hs && (sel_ch == CW'(c));
        mc_fifo_ch #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (push[c]),
            .wr_data(data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en  (pop[c]),
            .rd_data(head[c]),
            .full   (full[c]),
            .empty  (empty[c])
`ifdef MC_FIFO_ALMOST_FULL_EN
            ,
            .count  (count[c])
`endif
        );
`ifdef MC_FIFO_ALMOST_FULL_EN
        assign almost_full_o[c] = rdy_q && (count[c] >= (AW+1)'(AF_LEVEL));
`endif
    end

    // First non-empty channel at or after rr_q, wrapping modulo NUM_CH.
    always_comb begin
        logic [CW:0] idx;
        scan_ch = rr_q;
        any_ne  = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + (CW+1)'(i);
            if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
            if (!any_ne && !empty[idx[CW-1:0]]) begin
                scan_ch = idx[CW-1:0];
                any_ne  = 1'b1;
            end
        end
    end

    assign sel_ch  = (state_q == LOCKED) ? lock_q : scan_ch;
    assign valid_o = (state_q == LOCKED) ? !empty[lock_q] : any_ne;
    assign hs      = valid_o && grant_i;
    assign ch_o    = valid_o ? sel_ch : '0;
    assign data_o  = valid_o ? head[sel_ch] : '0;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE:   if (valid_o && !grant_i) begin
                        state_d = LOCKED;
                        lock_d  = scan_ch;
                    end
            LOCKED: if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hs) rr_d = (sel_ch == CW'(NUM_CH - 1)) ? '0 : sel_ch + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rr_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_fifo_arbiter.sv
// Directed bench for mc_fifo_arbiter. Expected output words are queued when
// stimulus is issued; a monitor pops and compares on every output handshake.
module tb_mc_fifo_arbiter;
    localparam int DW = 32;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC*DW-1:0] data_i;
    logic [NC-1:0]    valid_i;
    logic [NC-1:0]    grant_o;
    logic             grant_i;
    logic [DW-1:0]    data_o;
    logic [1:0]       ch_o;
    logic             valid_o;
`ifdef MC_FIFO_ALMOST_FULL_EN
    logic [NC-1:0]    almost_full_o;
`endif

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_fifo_arbiter #(
        .DATA_WIDTH(DW),
        .DEPTH     (4),
        .NUM_CH    (NC),
        .AF_LEVEL  (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (data_i),
        .valid_i(valid_i),
        .grant_o(grant_o),
        .grant_i(grant_i),
        .data_o (data_o),
        .ch_o   (ch_o),
        .valid_o(valid_o)
`ifdef MC_FIFO_ALMOST_FULL_EN
        ,
        .almost_full_o(almost_full_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int ch, input logic [DW-1:0] d);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input int ch, input logic [DW-1:0] d);
        data_i[ch*DW +: DW] = d;
        valid_i[ch]         = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1 && grant_i === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", {32'h0, data_o}, 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ch", 64'(ch_o), 64'(e.ch));
                check("sb_data", 64'(data_o), 64'(e.data));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        data_i  = '0;
        valid_i = '0;
        grant_i = 1'b0;

        // Reset
        #10;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_grant_o", 64'(grant_o), 64'd0);
        check("rst_ch_o", 64'(ch_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        #10 rst_n = 1'b1;
        step();
        check("post_rst_grant_o", 64'(grant_o), 64'hF);
        check("post_rst_valid_o", 64'(valid_o), 64'd0);

        // Round robin: two words per channel, grant_i held high
        grant_i = 1'b1;
        for (int c = 0; c < NC; c++) drive(c, 32'h1000_0000 + 32'(c*16));
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < NC; c++) push_exp(c, 32'h1000_0000 + 32'(c*16 + w));
        step();
        for (int c = 0; c < NC; c++) drive(c, 32'h1000_0001 + 32'(c*16));
        step();
        valid_i = '0;
        repeat (7) step();
        check("rr_drained_valid_o", 64'(valid_o), 64'd0);

        // Stall lock: ch2 shown and stalled, then ch0 (ahead in rr order) arrives
        grant_i = 1'b0;
        drive(2, 32'h5A5A5A5A);
        step();
        valid_i = '0;
        drive(0, 32'h0C0C0C0C);
        check("lock_first_ch", 64'(ch_o), 64'd2);
        check("lock_first_valid", 64'(valid_o), 64'd1);
        step();
        valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            check("lock_hold_ch", 64'(ch_o), 64'd2);
            check("lock_hold_data", 64'(data_o), 64'h5A5A5A5A);
            step();
        end
        grant_i = 1'b1;
        push_exp(2, 32'h5A5A5A5A);
        push_exp(0, 32'h0C0C0C0C);
        repeat (2) step();
        check("lock_drained_valid_o", 64'(valid_o), 64'd0);

        // Single word with one-cycle latency
        drive(1, 32'hA5A5A5A5);
        push_exp(1, 32'hA5A5A5A5);
        check("single_no_bypass", 64'(valid_o), 64'd0);
        step();
        valid_i = '0;
        check("single_valid_o", 64'(valid_o), 64'd1);
        check("single_ch_o", 64'(ch_o), 64'd1);
        check("single_data_o", 64'(data_o), 64'hA5A5A5A5);
        step();
        check("single_after_valid_o", 64'(valid_o), 64'd0);

        // Full channel: 5th write dropped, also blocked when read same cycle
        grant_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3, 32'h0000_0030 + 32'(i));
            step();
        end
        check("full_grant_o", 64'(grant_o), 64'h7);
        drive(3, 32'hFFFFFFFF);
        step();
        check("full_still_blocked", 64'(grant_o), 64'h7);
        grant_i = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(3, 32'h0000_0030 + 32'(i));
        step();
        valid_i = '0;
        check("full_grant_reopen", 64'(grant_o), 64'hF);
        repeat (3) step();
        check("full_drained_valid_o", 64'(valid_o), 64'd0);

`ifdef MC_FIFO_ALMOST_FULL_EN
        // Almost-full at 3 words with AF_LEVEL=3
        grant_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0000_0A00 + 32'(i));
            step();
            if (i == 1) check("af_at_2", 64'(almost_full_o), 64'd0);
        end
        valid_i = '0;
        check("af_at_3", 64'(almost_full_o), 64'd1);
        grant_i = 1'b1;
        push_exp(0, 32'h0000_0A00);
        step();
        grant_i = 1'b0;
        check("af_after_read", 64'(almost_full_o), 64'd0);
        grant_i = 1'b1;
        push_exp(0, 32'h0000_0A01);
        push_exp(0, 32'h0000_0A02);
        repeat (2) step();
        check("af_drained_valid_o", 64'(valid_o), 64'd0);
`endif

        grant_i = 1'b0;
        step();
        check("sb_leftover", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_fifo_arbiter.md
MC_FIFO_ARBITER -- requirements
Module: mc_fifo_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload bits per word.
REQ-002 SHALL have parameter DEPTH, default 4, words per channel FIFO; power of two, minimum 2.
REQ-003 SHALL have parameter NUM_CH, default 4, number of input channels; minimum 2.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold in words (used only with REQ-027).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port data_i  input  NUM_CH*DATA_WIDTH  packed channel payloads; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port valid_i  input  NUM_CH  per-channel write request.
REQ-009 SHALL have port grant_o  output  NUM_CH  per-channel write acceptance.
REQ-010 SHALL have port grant_i  input  1  downstream accepts the current output word.
REQ-011 SHALL have port data_o  output  DATA_WIDTH  head word of the selected channel.
REQ-012 SHALL have port ch_o  output  max(1,$clog2(NUM_CH))  index of the selected channel.
REQ-013 SHALL have port valid_o  output  1  data_o/ch_o hold a valid word.

Function
REQ-014 SHALL implement one independent circular FIFO per channel, with read/write pointers of $clog2(DEPTH)+1 bits; full = equal index and differing wrap bit; empty = pointers equal.
REQ-015 SHALL drive grant_o[c] = !full[c], independent of valid_i[c].
REQ-016 SHALL write data_i channel c into FIFO c on a rising edge where valid_i[c] && grant_o[c]; all channels may write in the same cycle.
REQ-017 SHALL perform a read on a rising edge where valid_o && grant_i, popping the selected channel only.
REQ-018 SHALL drive valid_o high whenever the locked channel is non-empty (LOCKED state) or any channel is non-empty (IDLE state).
REQ-019 SHALL, in IDLE, select the first non-empty channel scanning from rr_q upward, modulo NUM_CH.
REQ-020 SHALL implement states IDLE and LOCKED: IDLE->LOCKED when valid_o && !grant_i (the selected index is latched); LOCKED->IDLE on the handshake; otherwise the state is held.
REQ-021 SHALL keep data_o and ch_o stable while valid_o && !grant_i, even when higher-priority channels become non-empty.
REQ-022 SHALL set rr_q to (ch_o+1) mod NUM_CH on every handshake; rr_q is otherwise unchanged.
REQ-023 SHALL give one-cycle write-to-output latency: a word written into an empty system at edge k drives valid_o in the cycle after k; no same-cycle bypass.
REQ-024 SHALL block writes to a full channel even when that channel is read in the same cycle; grant_o rises in the cycle after the read.
REQ-025 SHALL accept a simultaneous write and read on the same non-full channel, with the count unchanged.

Reset
REQ-026 SHALL, while rst_n is low, clear all pointers, set rr_q=0, set state to IDLE, and drive valid_o=0, grant_o=0, ch_o=0, data_o=0; FIFO contents are discarded when reset is asserted mid-operation, and grant_o becomes all-ones in the first cycle after release.

Configuration
REQ-027 SHALL, when macro MC_FIFO_ALMOST_FULL_EN is defined, add output almost_full_o (NUM_CH bits), high when the channel count >= AF_LEVEL and 0 in reset; without the macro the port and its count logic SHALL be absent and all other behaviour is identical.

Verification
REQ-028 SHALL cover reset: rst_n low 20 ns -> valid_o=0 and grant_o=0 during reset; grant_o=4'b1111 at the first edge after release.
REQ-029 SHALL cover single word: ch1 writes 32'hA5A5A5A5 with grant_i=1 -> next cycle valid_o=1, ch_o=1, data_o=32'hA5A5A5A5; one cycle later valid_o=0.
REQ-030 SHALL cover stall lock: ch2 holds 32'h5A5A5A5A with grant_i=0, then ch0 is written -> ch_o stays 2 and data_o stays 32'h5A5A5A5A until grant_i=1.
REQ-031 SHALL cover round robin: 2 words per channel, grant_i=1 -> ch_o sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL cover full: 4 writes to ch3 with grant_i=0 -> grant_o[3]=0; a 5th write (32'hFFFFFFFF) is dropped; after 4 reads, data_o never shows 32'hFFFFFFFF.
REQ-033 SHALL cover almost-full: with MC_FIFO_ALMOST_FULL_EN defined and AF_LEVEL=3, 3 writes to ch0 -> almost_full_o[0]=1; one read -> 0.
